emu_time_scheduler: RTL and testbench

- Central emulation-time sequencer for the const_clock/clock instances.
- Collects each clock's current time_clock and selects the minimum over enabled clocks as the next global event time.
- Broadcasts that time as time_next and pulses a global advance strobe, so the clocks whose time equals time_next take their step.
- Adds host run/halt/single-step control, an optional stop time, and a step counter.

---
 rtl/emu_time_scheduler.sv | 134 +++++++++++++
 tb/tb_emu_time_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emu_time_scheduler.sv
// Emulation-time sequencer: picks the minimum enabled clock time, broadcasts it and strobes adv.
// Optional macro SCHED_WINNER_EN registers the index of the winning clock on the winner output.
module emu_time_scheduler #(
  parameter int N_CLK       = 4,
  parameter int STEP_BITS   = 32,
  parameter int TIME_FORMAT = 32,
  localparam int WIN_W      = (N_CLK > 1) ? $clog2(N_CLK) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              run,
  input  logic                              step_req,
  input  logic [N_CLK-1:0]                  clk_en,
  input  logic [N_CLK-1:0][TIME_FORMAT-1:0] time_clock_in,
  input  logic                              stop_en,
  input  logic [TIME_FORMAT-1:0]            stop_time,
  output logic [TIME_FORMAT-1:0]            time_next,
  output logic                              adv,
  output logic [1:0]                        state,
  output logic [STEP_BITS-1:0]              step_count,
  output logic                              done,
  output logic                              no_clk,
  output logic [WIN_W-1:0]                  winner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    ADV  = 2'd2,
    STOP = 2'd3
  } state_e;

  state_e                 state_q;
  logic [TIME_FORMAT-1:0] time_next_q;
  logic [STEP_BITS-1:0]   step_count_q;
  logic                   adv_q, done_q, no_clk_q, single_q;

  logic [TIME_FORMAT-1:0] min_time;
  logic                   any_en;
`ifdef SCHED_WINNER_EN
  logic [WIN_W-1:0]       min_idx;
  logic [WIN_W-1:0]       winner_q;
`endif

  // Strict '<' keeps the lowest index on ties.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    min_time = '0;
    any_en   = 1'b0;
`ifdef SCHED_WINNER_EN
    min_idx  = '0;
`endif
    for (int i = 0; i < N_CLK; i++) begin
      if (clk_en[i] && (!any_en || (time_clock_in[i] < min_time))) begin
        min_time = time_clock_in[i];
        any_en   = 1'b1;
`ifdef SCHED_WINNER_EN
        min_idx  = WIN_W'(i);
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      time_next_q  <= '0;
      step_count_q <= '0;
      adv_q        <= 1'b0;
      done_q       <= 1'b0;
      no_clk_q     <= 1'b0;
      single_q     <= 1'b0;
`ifdef SCHED_WINNER_EN
      winner_q     <= '0;
`endif
    end else begin
      adv_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (run) begin
            state_q  <= EVAL;
            single_q <= 1'b0;
          end else if (step_req) begin
            state_q  <= EVAL;
            single_q <= 1'b1;
          end
        end
        EVAL: begin
          if (!any_en) begin
            no_clk_q <= 1'b1;
            state_q  <= IDLE;
          end else if (stop_en && (min_time > stop_time)) begin
            time_next_q <= min_time;
            done_q      <= 1'b1;
            state_q     <= STOP;
          end else begin
            time_next_q <= min_time;
            no_clk_q    <= 1'b0;
            adv_q       <= 1'b1;
            state_q     <= ADV;
`ifdef SCHED_WINNER_EN
            winner_q    <= min_idx;
`endif
          end
        end
        ADV: begin
          if (step_count_q != '1) step_count_q <= step_count_q + STEP_BITS'(1);
          state_q <= (single_q || !run) ? IDLE : EVAL;
        end
        STOP: begin
          if ((!run && !step_req) || !stop_en) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign time_next  = time_next_q;
  assign adv        = adv_q;
  assign state      = state_q;
  assign step_count = step_count_q;
  assign done       = done_q;
  assign no_clk     = no_clk_q;
`ifdef SCHED_WINNER_EN
  assign winner     = winner_q;
`else
  assign winner     = '0;
`endif

endmodule

// File: tb/tb_emu_time_scheduler.sv
// Scoreboard bench for emu_time_scheduler: expected adv events are queued when stimulus is set up
// and popped by a negedge monitor that also advances the modelled clocks on each adv.
module tb_emu_time_scheduler;

  localparam int N  = 4;
  localparam int TW = 32;

  typedef struct packed {
    logic [TW-1:0] t;
    logic [1:0]    w;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 run, step_req, stop_en;
  logic [N-1:0]         clk_en;
  logic [N-1:0][TW-1:0] tc;
  logic [TW-1:0]        stop_time;
  logic [TW-1:0]        time_next;
  logic                 adv, done, no_clk;
  logic [1:0]           state;
  logic [31:0]          step_count;
  logic [1:0]           winner;

  logic [TW-1:0]        s_time_next;
  logic                 s_adv, s_done, s_no_clk;
  logic [1:0]           s_state;
  logic [1:0]           s_step_count;
  logic [1:0]           s_winner;

  int            n_tests = 0;
  int            n_fail  = 0;
  exp_t          sb[$];
  logic [TW-1:0] period[N];
  bit            clocks_live = 1'b0;
  bit            prev_adv    = 1'b0;

  emu_time_scheduler #(.N_CLK(N), .STEP_BITS(32), .TIME_FORMAT(TW)) dut (
    .clk(clk), .rst(rst), .run(run), .step_req(step_req), .clk_en(clk_en),
    .time_clock_in(tc), .stop_en(stop_en), .stop_time(stop_time),
    .time_next(time_next), .adv(adv), .state(state), .step_count(step_count),
    .done(done), .no_clk(no_clk), .winner(winner)
  );

  // Narrow counter copy to observe saturation.
  emu_time_scheduler #(.N_CLK(N), .STEP_BITS(2), .TIME_FORMAT(TW)) dut_sat (
    .clk(clk), .rst(rst), .run(run), .step_req(step_req), .clk_en(clk_en),
    .time_clock_in(tc), .stop_en(stop_en), .stop_time(stop_time),
    .time_next(s_time_next), .adv(s_adv), .state(s_state), .step_count(s_step_count),
    .done(s_done), .no_clk(s_no_clk), .winner(s_winner)
  );

  always #5 clk = ~clk;

  // Monitor: pop one expectation per adv, then step the clocks that matched time_next.
  always @(negedge clk) begin
    if (!rst) begin
      prev_adv = 1'b0;
    end else begin
      if (adv) begin
        n_tests++;
        if (prev_adv) begin
          n_fail++;
          $display("FAIL adv_duty: adv high on consecutive cycles");
        end
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_adv: time_next=%0d with no expected step", time_next);
        end else begin
          exp_t e;
          logic [1:0] ew;
          e = sb.pop_front();
`ifdef SCHED_WINNER_EN
          ew = e.w;
`else
          ew = 2'd0;
`endif
          if (time_next !== e.t || winner !== ew) begin
            n_fail++;
            $display("FAIL adv_event: time_next=%0d winner=%0d, expected time_next=%0d winner=%0d",
                     time_next, winner, e.t, ew);
          end
        end
        if (clocks_live)
          for (int i = 0; i < N; i++)
            if (clk_en[i] && tc[i] == time_next) tc[i] = tc[i] + period[i];
      end
      prev_adv = adv;
    end
  end

  // Reference model: queue the next `steps` adv events from the current bench clock state.
  task automatic push_model(input int steps);
    logic [TW-1:0] t[N];
    for (int i = 0; i < N; i++) t[i] = tc[i];
    for (int k = 0; k < steps; k++) begin
      exp_t e;
      bit   found = 1'b0;
      e = '0;
      for (int i = 0; i < N; i++)
        if (clk_en[i] && (!found || t[i] < e.t)) begin
          e.t   = t[i];
          e.w   = 2'(i);
          found = 1'b1;
        end
      sb.push_back(e);
      for (int i = 0; i < N; i++)
        if (clk_en[i] && t[i] == e.t) t[i] = t[i] + period[i];
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    run = 1'b0; step_req = 1'b0; stop_en = 1'b0; stop_time = '0;
    clk_en = '1; clocks_live = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Waits for the scoreboard to empty, dropping run inside the final ADV cycle.
  task automatic drain(input string name);
    for (int c = 0; c < 200 && sb.size() != 0; c++) begin
      @(negedge clk);
      #1;
    end
    run = 1'b0;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d expected steps never seen, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_adv(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = adv;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: adv=0 after 50 cycles, required 1", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    run = 1'b0; step_req = 1'b0; stop_en = 1'b0; stop_time = '0; clk_en = '1;
    tc = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (state !== 2'd0 || adv !== 1'b0 || time_next !== '0 || step_count !== '0 ||
          done !== 1'b0 || no_clk !== 1'b0 || winner !== '0) begin
        n_fail++;
        $display("FAIL reset_idle: state=%0d adv=%0b tn=%0d sc=%0d done=%0b no_clk=%0b win=%0d, required all 0",
                 state, adv, time_next, step_count, done, no_clk, winner);
      end
    end
  endtask

  task automatic test_free_run();
    do_reset();
    tc[0] = 40; tc[1] = 10; tc[2] = 25; tc[3] = 10;
    period[0] = 40; period[1] = 20; period[2] = 25; period[3] = 30;
    clocks_live = 1'b1;
    push_model(8);
    @(negedge clk);
    run = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (state !== 2'd1 || adv !== 1'b0) begin
      n_fail++;
      $display("FAIL free_run_eval: state=%0d adv=%0b, required state=1 adv=0", state, adv);
    end
    @(posedge clk); #1;
    n_tests++;
    if (state !== 2'd2 || adv !== 1'b1 || time_next !== 32'd10) begin
      n_fail++;
      $display("FAIL free_run_first_adv: state=%0d adv=%0b tn=%0d, required 2/1/10", state, adv, time_next);
    end
    drain("free_run");
    repeat (3) @(negedge clk);
    n_tests++;
    if (state !== 2'd0 || step_count !== 32'd8 || s_step_count !== 2'd3) begin
      n_fail++;
      $display("FAIL free_run_count: state=%0d sc=%0d sat_sc=%0d, required 0/8/3", state, step_count, s_step_count);
    end
  endtask

  task automatic test_single_step();
    do_reset();
    tc[0] = 7; tc[1] = 3; tc[2] = 9; tc[3] = 5;
    push_model(1);
    @(negedge clk);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    wait_adv("single_step");
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++;
    if (state !== 2'd0 || step_count !== 32'd1 || time_next !== 32'd3 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL single_step_end: state=%0d sc=%0d tn=%0d pending=%0d, required 0/1/3/0",
               state, step_count, time_next, sb.size());
    end
  endtask

  task automatic test_stop_time();
    bit hit = 1'b0;
    do_reset();
    tc[0] = 100; tc[1] = 120; tc[2] = 130; tc[3] = 140;
    period[0] = 50; period[1] = 50; period[2] = 50; period[3] = 50;
    clocks_live = 1'b1;
    stop_en = 1'b1; stop_time = 100;
    push_model(1);
    @(negedge clk);
    run = 1'b1;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      hit = (state == 2'd3);
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL stop_reach: state=%0d, required 3", state);
    end
    repeat (6) @(negedge clk);
    n_tests++;
    if (state !== 2'd3 || done !== 1'b1 || time_next !== 32'd120 || step_count !== 32'd1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL stop_hold: state=%0d done=%0b tn=%0d sc=%0d pending=%0d, required 3/1/120/1/0",
               state, done, time_next, step_count, sb.size());
    end
    run = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (state !== 2'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_exit: state=%0d done=%0b, required 0/0", state, done);
    end
  endtask

  task automatic test_no_clk();
    do_reset();
    clk_en = '0;
    tc[0] = 1; tc[1] = 2; tc[2] = 55; tc[3] = 3;
    @(negedge clk);
    run = 1'b1;
    repeat (6) @(negedge clk);
    n_tests++;
    if (no_clk !== 1'b1 || time_next !== '0 || step_count !== '0) begin
      n_fail++;
      $display("FAIL no_clk_set: no_clk=%0b tn=%0d sc=%0d, required 1/0/0", no_clk, time_next, step_count);
    end
    clk_en = 4'b0100;
    push_model(1);
    drain("mask");
    repeat (3) @(negedge clk);
    n_tests++;
    if (no_clk !== 1'b0 || time_next !== 32'd55 || state !== 2'd0) begin
      n_fail++;
      $display("FAIL mask_step: no_clk=%0b tn=%0d state=%0d, required 0/55/0", no_clk, time_next, state);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tc[0] = 5; tc[1] = 6; tc[2] = 7; tc[3] = 8;
    push_model(1);
    @(negedge clk);
    run = 1'b1;
    wait_adv("async_reset");
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (adv !== 1'b0 || state !== 2'd0 || step_count !== '0 || time_next !== '0) begin
      n_fail++;
      $display("FAIL async_reset: adv=%0b state=%0d sc=%0d tn=%0d, required 0/0/0/0",
               adv, state, step_count, time_next);
    end
    run = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_single_step();
    test_stop_time();
    test_no_clk();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
